matrix_stream_out: RTL and testbench

Read-side streamer for a `matrix_unit` storage instance. On `start` it latches the stored matrix's dimensions and walks the matrix row-major through the unit's combinational read port (`r_row`/`r_col` → `r_data`). It emits a valid/ready stream: two header beats (rows, cols) followed by every element. The stream feeds the UART/display formatter, so a stored matrix can be printed without the consumer knowing its size.

---
 rtl/project_pkg.sv | 35 +++
 rtl/matrix_addr_walker.sv | 77 +++++++
 rtl/matrix_stream_out.sv | 186 ++++++++++++++++++
 tb/tb_matrix_stream_out.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// project_pkg
// Shared types and constants for the matrix storage and streaming blocks.
//   MAX_DIM          largest legal row/col count of a stored matrix
//   DIM_W            width of a row/col count or index
//   matrix_element_t signed 8-bit matrix cell
//   matrix_t         dims, validity flag and cell array of a stored matrix
//   stream_state_t   state of matrix_stream_out, visible to benches
package project_pkg;

    localparam int MAX_DIM = 5;
    localparam int DIM_W   = 3;
    localparam int ELEM_W  = 8;

    typedef logic signed [ELEM_W-1:0] matrix_element_t;

    typedef struct packed {
        logic [DIM_W-1:0]                        rows;
        logic [DIM_W-1:0]                        cols;
        logic                                    is_valid;
        matrix_element_t [MAX_DIM*MAX_DIM-1:0]   cells;
    } matrix_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR_R = 2'd1,
        ST_HDR_C = 2'd2,
        ST_DATA  = 2'd3
    } stream_state_t;

    // A dimension is usable when it is non-zero and fits the storage.
    function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
        return (d != '0) && (int'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_addr_walker.sv
// matrix_addr_walker
// Row-major row/col counter used as the read pointer of matrix_stream_out.
//   clk, rst        clock, synchronous active-high reset
//   load_i          latch rows_i/cols_i and clear the pointer to (0,0)
//   rows_i, cols_i  dimensions to latch on load
//   adv_i           step the pointer to the next element (col first)
//   row_o, col_o    current pointer
//   cols_o          latched column count
//   is_eol_o        pointer sits on the last column of a row
//   is_last_o       pointer sits on the final element (R-1, C-1)
module matrix_addr_walker
    import project_pkg::DIM_W;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [DIM_W-1:0] rows_i,
    input  logic [DIM_W-1:0] cols_i,
    input  logic             adv_i,
    output logic [DIM_W-1:0] row_o,
    output logic [DIM_W-1:0] col_o,
    output logic [DIM_W-1:0] cols_o,
    output logic             is_eol_o,
    output logic             is_last_o
);

    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] rows_q, rows_d;
    logic [DIM_W-1:0] cols_q, cols_d;

    assign is_eol_o  = (col_q == cols_q - DIM_W'(1));
    assign is_last_o = is_eol_o && (row_q == rows_q - DIM_W'(1));

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        rows_d = rows_q;
        cols_d = cols_q;
        if (load_i) begin
            rows_d = rows_i;
            cols_d = cols_i;
            row_d  = '0;
            col_d  = '0;
        end else if (adv_i) begin
            if (is_last_o) begin
                // Wrap to the origin so the address never leaves the array.
                row_d = '0;
                col_d = '0;
            end else if (is_eol_o) begin
                row_d = row_q + DIM_W'(1);
                col_d = '0;
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            col_q  <= '0;
            rows_q <= '0;
            cols_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            rows_q <= rows_d;
            cols_q <= cols_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign cols_o = cols_q;

endmodule

// File: rtl/matrix_stream_out.sv
// matrix_stream_out
// Streams a stored matrix out of a matrix_unit as valid/ready beats:
// rows header, cols header, then every element in row-major order.
//   clk, rst             clock, synchronous active-high reset
//   start, abort         begin a transfer (idle only) / cancel it
//   src_rows/cols/valid  dims and validity of the stored matrix
//   r_row, r_col, r_data combinational read port of the matrix_unit
//   out_valid/ready      beat handshake; out_data carries header or element
//   out_hdr/eol/last     beat flags
//   busy, done, err      transfer active / finished pulse / rejected pulse
module matrix_stream_out
    import project_pkg::DIM_W;
    import project_pkg::ELEM_W;
    import project_pkg::stream_state_t;
    import project_pkg::ST_IDLE;
    import project_pkg::ST_HDR_R;
    import project_pkg::ST_HDR_C;
    import project_pkg::ST_DATA;
    import project_pkg::dim_ok;
#(
    parameter int MAX_DIM = project_pkg::MAX_DIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  src_rows,
    input  logic [DIM_W-1:0]  src_cols,
    input  logic              src_valid,
    output logic [DIM_W-1:0]  r_row,
    output logic [DIM_W-1:0]  r_col,
    input  logic [ELEM_W-1:0] r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_hdr,
    output logic              out_eol,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    stream_state_t     state_q, state_d;
    logic              valid_q, valid_d;
    logic [ELEM_W-1:0] data_q, data_d;
    logic              hdr_q, hdr_d;
    logic              eol_q, eol_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              walk_load;
    logic              walk_adv;
    logic [DIM_W-1:0]  walk_cols;
    logic              walk_eol;
    logic              walk_last;
    logic              hs;
    logic              start_ok;

    matrix_addr_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .load_i    (walk_load),
        .rows_i    (src_rows),
        .cols_i    (src_cols),
        .adv_i     (walk_adv),
        .row_o     (r_row),
        .col_o     (r_col),
        .cols_o    (walk_cols),
        .is_eol_o  (walk_eol),
        .is_last_o (walk_last)
    );

    assign hs       = valid_q && out_ready;
    assign start_ok = src_valid && dim_ok(src_rows, MAX_DIM) && dim_ok(src_cols, MAX_DIM);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        data_d    = data_q;
        hdr_d     = hdr_q;
        eol_d     = eol_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        walk_load = 1'b0;
        walk_adv  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start) begin
                if (start_ok) begin
                    state_d   = ST_HDR_R;
                    valid_d   = 1'b1;
                    data_d    = ELEM_W'(src_rows);
                    hdr_d     = 1'b1;
                    eol_d     = 1'b0;
                    last_d    = 1'b0;
                    busy_d    = 1'b1;
                    walk_load = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (abort) begin
            // Abort takes priority over any handshake-driven advance.
            state_d = ST_IDLE;
            valid_d = 1'b0;
            hdr_d   = 1'b0;
            eol_d   = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else if (hs) begin
            case (state_q)
                ST_HDR_R: begin
                    data_d  = ELEM_W'(walk_cols);
                    state_d = ST_HDR_C;
                end
                ST_HDR_C: begin
                    // Flags describe the element being loaded, i.e. the
                    // pointer position before it advances.
                    data_d   = r_data;
                    hdr_d    = 1'b0;
                    eol_d    = walk_eol;
                    last_d   = walk_last;
                    walk_adv = 1'b1;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    if (last_q) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        eol_d   = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d   = r_data;
                        eol_d    = walk_eol;
                        last_d   = walk_last;
                        walk_adv = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            hdr_q   <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            hdr_q   <= hdr_d;
            eol_q   <= eol_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_hdr   = hdr_q;
    assign out_eol   = eol_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_stream_out.sv
module tb_matrix_stream_out;
    import project_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] src_rows = '0;
    logic [2:0] src_cols = '0;
    logic       src_valid = 1'b0;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [7:0] r_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_hdr;
    logic       out_eol;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct packed {
        logic [7:0] data;
        logic       hdr;
        logic       eol;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] mem [8][8];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the matrix_unit read port.
    assign r_data = mem[r_row][r_col];

    matrix_stream_out #(.MAX_DIM(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .src_rows  (src_rows),
        .src_cols  (src_cols),
        .src_valid (src_valid),
        .r_row     (r_row),
        .r_col     (r_col),
        .r_data    (r_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_hdr   (out_hdr),
        .out_eol   (out_eol),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem[r][c] = 8'd0;
    endtask

    task automatic push_expected(input int nr, input int nc);
        beat_t b;
        b = '{data: 8'(nr), hdr: 1'b1, eol: 1'b0, last: 1'b0};
        exp_q.push_back(b);
        b = '{data: 8'(nc), hdr: 1'b1, eol: 1'b0, last: 1'b0};
        exp_q.push_back(b);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++) begin
                b.data = mem[r][c];
                b.hdr  = 1'b0;
                b.eol  = (c == nc - 1);
                b.last = (r == nr - 1) && (c == nc - 1);
                exp_q.push_back(b);
            end
    endtask

    // Pulse start for one edge; returns in cycle N+1.
    task automatic do_start(input int nr, input int nc, input logic vld, input logic accept);
        src_rows  = 3'(nr);
        src_cols  = 3'(nc);
        src_valid = vld;
        if (accept) push_expected(nr, nc);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    // Consume beats against the scoreboard.
    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
    // abort_at > 0: assert abort in the cycle after that many handshakes.
    // restart_at > 0: pulse start in that cycle (must be ignored).
    // exp_done > 0: cycle (counted from the start edge) where done must be high.
    task automatic run_stream(input int mode, input int abort_at, input int restart_at, input int exp_done);
        int    c = 1;
        int    hs = 0;
        int    done_c = -1;
        int    dones = 0;
        int    errs = 0;
        logic  stall_prev = 1'b0;
        logic  abort_prev = 1'b0;
        logic  finished = 1'b0;
        beat_t prev_b;
        beat_t cur_b;
        beat_t e;
        while (c < 300 && !finished) begin
            cur_b = '{data: out_data, hdr: out_hdr, eol: out_eol, last: out_last};
            if (done) begin
                dones++;
                done_c = c;
            end
            if (err) errs++;
            if (abort_prev) begin
                abort = 1'b0;
                chk("abort_valid", int'(out_valid), 0);
                chk("abort_busy", int'(busy), 0);
                for (int k = 0; k < 3; k++) begin
                    if (done) dones++;
                    next_cycle();
                end
                chk("abort_no_done", dones, 0);
                exp_q.delete();
                finished = 1'b1;
            end else if (done_c >= 0 && exp_q.size() == 0) begin
                finished = 1'b1;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
                start = (c == restart_at);
                if (abort_at > 0 && hs == abort_at) begin
                    abort = 1'b1;
                    out_ready = 1'b0;
                    abort_prev = 1'b1;
                end
                if (stall_prev) chk("stall_hold", int'(cur_b), int'(prev_b));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("beat c=%0d data=%0d hdr=%0b eol=%0b last=%0b",
                                 c, $signed(out_data), out_hdr, out_eol, out_last);
                        chk("beat_data", int'(out_data), int'(e.data));
                        chk("beat_flags", int'({out_hdr, out_eol, out_last}),
                            int'({e.hdr, e.eol, e.last}));
                    end
                    hs++;
                end
                stall_prev = out_valid && !out_ready;
                prev_b = cur_b;
                next_cycle();
                c++;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        if (!finished) chk("timeout", 1, 0);
        chk("stream_err", errs, 0);
        if (abort_at == 0) chk("done_count", dones, 1);
        if (exp_done > 0) chk("done_cycle", done_c, exp_done);
        chk("end_idle", int'(dut.state_q), int'(ST_IDLE));
    endtask

    task automatic check_reject(input string tag, input int nr, input int nc, input logic vld);
        do_start(nr, nc, vld, 1'b0);
        chk({tag, "_err"}, int'(err), 1);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        next_cycle();
        chk({tag, "_err_pulse"}, int'(err), 0);
        chk({tag, "_valid2"}, int'(out_valid), 0);
        $display("reject %s rows=%0d cols=%0d valid=%0b", tag, nr, nc, vld);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_data"}, int'(out_data), 0);
        chk({tag, "_flags"}, int'({out_hdr, out_eol, out_last}), 0);
        chk({tag, "_status"}, int'({busy, done, err}), 0);
        chk({tag, "_ptr"}, int'({r_row, r_col}), 0);
        chk({tag, "_state"}, int'(dut.state_q), int'(ST_IDLE));
    endtask

    initial begin
        clear_mem();
        rst = 1'b1;
        repeat (3) next_cycle();
        check_all_zero("reset");
        rst = 1'b0;
        next_cycle();

        // 2x3 matrix, ready held high
        clear_mem();
        mem[0][0] = 8'd10;
        mem[1][2] = 8'hFB;
        do_start(2, 3, 1'b1, 1'b1);
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_busy", int'(busy), 1);
        run_stream(0, 0, 0, 9);

        // Same matrix with backpressure
        do_start(2, 3, 1'b1, 1'b1);
        run_stream(1, 0, 0, 0);

        // Rejected starts
        check_reject("rej_invalid", 2, 3, 1'b0);
        check_reject("rej_zero", 0, 3, 1'b1);
        check_reject("rej_big", 6, 2, 1'b1);

        // 1x1 matrix holding -1
        clear_mem();
        mem[0][0] = 8'hFF;
        do_start(1, 1, 1'b1, 1'b1);
        run_stream(0, 0, 0, 4);

        // Abort after third handshake, then full replay
        clear_mem();
        mem[0][0] = 8'd10;
        mem[1][2] = 8'hFB;
        do_start(2, 3, 1'b1, 1'b1);
        run_stream(0, 3, 0, 0);
        do_start(2, 3, 1'b1, 1'b1);
        run_stream(0, 0, 0, 9);

        // Second start during DATA is ignored
        do_start(2, 3, 1'b1, 1'b1);
        run_stream(0, 0, 5, 9);

        // Reset in the middle of DATA
        do_start(2, 3, 1'b1, 1'b1);
        out_ready = 1'b1;
        repeat (4) next_cycle();
        chk("pre_rst_state", int'(dut.state_q), int'(ST_DATA));
        out_ready = 1'b0;
        rst = 1'b1;
        next_cycle();
        check_all_zero("mid_rst");
        rst = 1'b0;
        exp_q.delete();
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
